mem_stage: RTL

- Pipeline stage directly downstream of the ALU stage; consumes the ALU result bus each cycle.
- Performs RV64 loads and stores against a handshaked data-memory port, aligns and extends load data, and resolves branches from the ALU compare bit.
- Produces the register write-back bus and the branch-redirect pulse that feeds back to the ALU's take_branch input.
- Stalls upstream while a memory access is outstanding.

---
 rtl/mem_pkg.sv | 52 +++++
 rtl/mem_align.sv | 42 ++++
 rtl/mem_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: access-size encodings, RISC-V
// load/store funct3 values, FSM state encoding and size-mask helpers.
package mem_pkg;

  localparam int XLEN_DEF = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_e;

  // Address low bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_lo_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  // Byte-strobe pattern of an access placed at lane 0.
  function automatic logic [7:0] size_byte_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for the memory stage.
//   addr_lo_i  : low 3 bits of the (size-aligned) effective address
//   funct3_i   : RISC-V load/store funct3 (size in [1:0], unsigned in [2])
//   st_data_i  : rs2 value   -> st_wdata_o (lane-shifted), st_wstrb_o
//   ld_rdata_i : doubleword  -> ld_data_o (lane-selected, sign/zero-extended)
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] st_data_i,
  output logic [63:0] st_wdata_o,
  output logic [7:0]  st_wstrb_o,
  input  logic [63:0] ld_rdata_i,
  output logic [63:0] ld_data_o
);

  logic [1:0]  sz;
  logic [5:0]  sh;
  logic [63:0] lane;
  logic        sx;

  assign sz   = funct3_i[1:0];
  assign sh   = {addr_lo_i, 3'b000};
  assign lane = ld_rdata_i >> sh;
  // funct3[2] selects zero-extension; for doublewords (incl. 111) it is moot.
  assign sx   = ~funct3_i[2];

  assign st_wdata_o = st_data_i << sh;
  assign st_wstrb_o = size_byte_mask(sz) << addr_lo_i;

  always_comb begin
    ld_data_o = lane;
    case (mem_size_e'(sz))
      SZ_B:    ld_data_o = {{56{sx & lane[7]}},  lane[7:0]};
      SZ_H:    ld_data_o = {{48{sx & lane[15]}}, lane[15:0]};
      SZ_W:    ld_data_o = {{32{sx & lane[31]}}, lane[31:0]};
      default: ld_data_o = lane;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: ALU write-back pass-through, branch resolution and
// RV64 loads/stores over a ready/rvalid handshaked data-memory port.
// Ports:
//   CLK, RST_N            clock, synchronous active-low reset
//   alu_*/rd/funct3/...   op from the ALU stage, sampled only when idle
//   stall_o               high while a memory access is in flight
//   wb_*_o                register-file write port (1-cycle wb_en_o)
//   take_branch_o/target  branch redirect pulse and target
//   dmem_*                data-memory request / response port
//   misalign_o            misaligned-access pulse
// Build option: define MEM_MISALIGN_CHECK_EN to reject misaligned accesses
// (misalign_o pulse, no request). Otherwise the address is forced to size
// alignment and misalign_o is tied low.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [XLEN-1:0]   alu_res_i,
  input  logic              alu_wb_en_i,
  input  logic [4:0]        rd_i,
  input  logic              load_flag_i,
  input  logic              mem_en_i,
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic              branch_flag_i,
  input  logic [XLEN-1:0]   branch_offset_i,
  input  logic [XLEN-1:0]   PC_i,
  output logic              stall_o,
  output logic              wb_en_o,
  output logic [4:0]        wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              take_branch_o,
  output logic [XLEN-1:0]   branch_target_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [63:0]       dmem_wdata_o,
  output logic [7:0]        dmem_wstrb_o,
  input  logic              dmem_ready_i,
  input  logic              dmem_rvalid_i,
  input  logic [63:0]       dmem_rdata_i,
  output logic              misalign_o
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              load_q, load_d;
  logic [63:0]       sdata_q, sdata_d;
  logic              wb_en_q, wb_en_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              br_q, br_d;
  logic [XLEN-1:0]   tgt_q, tgt_d;

  logic [2:0]        lo_mask;
  logic [ADDR_W-1:0] eff_addr;
  logic              issue;
  logic [63:0]       st_wdata, ld_data;
  logic [7:0]        st_wstrb;
  logic              req, st_req;

  assign lo_mask  = size_lo_mask(funct3_i[1:0]);
  assign eff_addr = {alu_res_i[ADDR_W-1:3], alu_res_i[2:0] & ~lo_mask};

`ifdef MEM_MISALIGN_CHECK_EN
  logic mis_q, mis_d;
  logic misal;
  assign misal      = |(alu_res_i[2:0] & lo_mask);
  assign issue      = ~misal;
  assign misalign_o = mis_q;
`else
  assign issue      = 1'b1;
  assign misalign_o = 1'b0;
`endif

  mem_align u_align (
    .addr_lo_i  (addr_q[2:0]),
    .funct3_i   (f3_q),
    .st_data_i  (sdata_q),
    .st_wdata_o (st_wdata),
    .st_wstrb_o (st_wstrb),
    .ld_rdata_i (dmem_rdata_i),
    .ld_data_o  (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    load_d    = load_q;
    sdata_d   = sdata_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    br_d      = 1'b0;
    tgt_d     = tgt_q;
`ifdef MEM_MISALIGN_CHECK_EN
    mis_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mem_en_i) begin
          if (issue) begin
            addr_d  = eff_addr;
            f3_d    = funct3_i;
            rd_d    = rd_i;
            load_d  = load_flag_i;
            sdata_d = store_data_i;
            state_d = ST_REQ;
          end
`ifdef MEM_MISALIGN_CHECK_EN
          else begin
            mis_d = 1'b1;
          end
`endif
        end else if (branch_flag_i) begin
          if (alu_res_i[0]) begin
            br_d  = 1'b1;
            tgt_d = PC_i + branch_offset_i;
          end
        end else begin
          wb_en_d   = alu_wb_en_i;
          wb_rd_d   = rd_i;
          wb_data_d = alu_res_i;
        end
      end
      ST_REQ: begin
        if (dmem_ready_i) state_d = load_q ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        if (dmem_rvalid_i) begin
          wb_en_d   = (rd_q != 5'd0);
          wb_rd_d   = rd_q;
          wb_data_d = ld_data;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      load_q    <= 1'b0;
      sdata_q   <= '0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      br_q      <= 1'b0;
      tgt_q     <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      load_q    <= load_d;
      sdata_q   <= sdata_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      br_q      <= br_d;
      tgt_q     <= tgt_d;
`ifdef MEM_MISALIGN_CHECK_EN
      mis_q     <= mis_d;
`endif
    end
  end

  // Memory-port fields are held from the latched op and only driven in REQ,
  // so they read as zero whenever no request is outstanding.
  assign req    = (state_q == ST_REQ);
  assign st_req = req & ~load_q;

  assign stall_o         = (state_q != ST_IDLE);
  assign wb_en_o         = wb_en_q;
  assign wb_rd_o         = wb_rd_q;
  assign wb_data_o       = wb_data_q;
  assign take_branch_o   = br_q;
  assign branch_target_o = tgt_q;
  assign dmem_req_o      = req;
  assign dmem_we_o       = st_req;
  assign dmem_addr_o     = req ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
  assign dmem_wdata_o    = st_req ? st_wdata : '0;
  assign dmem_wstrb_o    = st_req ? st_wstrb : '0;

endmodule
